// File: rtl/jzjpcc_endianness_functions.sv
// Byte-order helpers shared across the jzjpcc pipeline.
package jzjpcc_endianness_functions;

    function automatic logic [31:0] toBigEndian32(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

endpackage

// File: rtl/jzjpcc_memory_backend_pkg.sv
// Shared types and address decode for the jzjpcc unified memory backend.
// Optional input synchroniser macro used by the slice: JZJPCC_MMIO_INPUT_SYNC_EN.
package jzjpcc_memory_backend_pkg;

    localparam int MMIO_MAX_COUNT = 16;
    localparam int MMIO_INDEX_W   = $clog2(MMIO_MAX_COUNT);

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_MMIO_OUT,
        REGION_MMIO_IN
    } region_t;

    // Offsets below the MMIO base wrap to huge 32-bit values and so never match.
    function automatic region_t decodeRegion(
        input logic [29:0]  word_addr,
        input int unsigned  ram_a_width,
        input int unsigned  mmio_count,
        input logic [31:0]  mmio_base
    );
        logic [31:0] offset;
        offset = {2'b00, word_addr} - {2'b00, mmio_base[31:2]};
        if ((word_addr >> ram_a_width) == '0)
            return REGION_RAM;
        if (offset < mmio_count)
            return REGION_MMIO_OUT;
        if (offset < 2 * mmio_count)
            return REGION_MMIO_IN;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/jzjpcc_memory_backend_data_if.sv
// Memory-stage data port between the pipeline and the memory backend.
interface jzjpcc_memory_backend_data_if;
    logic        we;
    logic [31:2] addr;
    logic [31:0] wdata;
    logic [3:0]  bytemask;
    logic [31:0] rdata;

    modport backend (input we, addr, wdata, bytemask, output rdata);
    modport stage   (output we, addr, wdata, bytemask, input rdata);
endinterface

// File: rtl/jzjpcc_inferred_sram.sv
// Inferred true dual-port SRAM with byte-lane writes; reads return pre-write data.
// INITIAL_MEM_CONTENTS is forwarded for the implementation flow's memory preload step.
module jzjpcc_inferred_sram #(
    parameter string INITIAL_MEM_CONTENTS = "",
    parameter int    A_WIDTH              = 12
) (
    input  logic               clock,
    input  logic [A_WIDTH-1:0] addr_a,
    input  logic               we_a,
    input  logic [3:0]         mask_a,
    input  logic [31:0]        d_a,
    output logic [31:0]        q_a,
    input  logic [A_WIDTH-1:0] addr_b,
    input  logic               we_b,
    input  logic [3:0]         mask_b,
    input  logic [31:0]        d_b,
    output logic [31:0]        q_b
);
    logic [31:0] mem [2**A_WIDTH];

    // Port B is ordered last so it wins a same-word, same-lane collision.
    always_ff @(posedge clock) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
        for (int b = 0; b < 4; b++) begin
            if (we_a && mask_a[b])
                mem[addr_a][8*b +: 8] <= d_a[8*b +: 8];
            if (we_b && mask_b[b])
                mem[addr_b][8*b +: 8] <= d_b[8*b +: 8];
        end
    end

endmodule

// File: rtl/jzjpcc_mmio_regfile.sv
// MMIO output registers (byte-maskable), input channels and registered read mux.
// Macro JZJPCC_MMIO_INPUT_SYNC_EN adds a 2-flop synchroniser on every input channel.
module jzjpcc_mmio_regfile
    import jzjpcc_memory_backend_pkg::*;
#(
    parameter int MMIO_COUNT = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        write_en,
    input  logic                        select_in,
    input  logic [MMIO_INDEX_W-1:0]     index,
    input  logic [31:0]                 wdata,
    input  logic [3:0]                  bytemask,
    input  logic [MMIO_COUNT-1:0][31:0] inputs,
    output logic [MMIO_COUNT-1:0][31:0] outputs,
    output logic [31:0]                 rdata
);
    logic [MMIO_COUNT-1:0][31:0] input_view;
    logic [31:0]                 read_value;

`ifdef JZJPCC_MMIO_INPUT_SYNC_EN
    logic [MMIO_COUNT-1:0][31:0] sync_meta;
    logic [MMIO_COUNT-1:0][31:0] sync_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= inputs;
            sync_out  <= sync_meta;
        end
    end

    assign input_view = sync_out;
`else
    assign input_view = inputs;
`endif

    always_comb begin
        read_value = '0;
        for (int i = 0; i < MMIO_COUNT; i++) begin
            if (index == i[MMIO_INDEX_W-1:0])
                read_value = select_in ? input_view[i] : outputs[i];
        end
    end

    // rdata captures the pre-write register value, giving old-data on read-during-write.
    always_ff @(posedge clock) begin
        if (reset) begin
            outputs <= '0;
            rdata   <= '0;
        end else begin
            rdata <= read_value;
            for (int i = 0; i < MMIO_COUNT; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (write_en && index == i[MMIO_INDEX_W-1:0] && bytemask[b])
                        outputs[i][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/jzjpcc_mmio_memory_backend.sv
// Unified memory backend: SRAM port A for fetch, port B plus MMIO for the memory stage.
// Optional macro JZJPCC_MMIO_INPUT_SYNC_EN synchronises mmioInputs inside the regfile.
module jzjpcc_mmio_memory_backend
    import jzjpcc_memory_backend_pkg::*;
    import jzjpcc_endianness_functions::*;
#(
    parameter string       INITIAL_MEM_CONTENTS = "",
    parameter int          RAM_A_WIDTH          = 12,
    parameter int          PC_MAX_B             = 13,
    parameter int          MMIO_COUNT           = 8,
    parameter logic [31:0] MMIO_BASE            = 32'hFFFF_FF80
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [PC_MAX_B:2]             instructionAddressToLatch,
    output logic [29:0]                   instruction_fetch,
    jzjpcc_memory_backend_data_if.backend memDataBackendIF,
    input  logic [MMIO_COUNT-1:0][31:0]   mmioInputs,
    output logic [MMIO_COUNT-1:0][31:0]   mmioOutputs,
    output logic                          accessFault
);
    logic [31:0]             fetch_word_addr;
    logic [31:0]             data_word_addr;
    logic [31:0]             mmio_offset;
    logic [MMIO_INDEX_W-1:0] mmio_index;
    region_t                 region_dec;
    region_t                 region_q;
    logic                    illegal;
    logic                    ram_we;
    logic                    mmio_we;
    logic [31:0]             sram_q_a;
    logic [31:0]             sram_q_b;
    logic [31:0]             fetch_be;
    logic [31:0]             mmio_rdata;
    logic [31:0]             mem_data_read;

    assign fetch_word_addr = 32'(instructionAddressToLatch);
    assign data_word_addr  = {2'b00, memDataBackendIF.addr};

    always_comb begin
        region_dec  = decodeRegion(memDataBackendIF.addr, RAM_A_WIDTH, MMIO_COUNT, MMIO_BASE);
        mmio_offset = data_word_addr - {2'b00, MMIO_BASE[31:2]};
        mmio_index  = (region_dec == REGION_MMIO_IN)
                    ? MMIO_INDEX_W'(mmio_offset - 32'(MMIO_COUNT))
                    : mmio_offset[MMIO_INDEX_W-1:0];
        illegal     = (region_dec == REGION_NONE)
                   || (region_dec == REGION_MMIO_IN && memDataBackendIF.we);
    end

    assign ram_we  = memDataBackendIF.we && (region_dec == REGION_RAM) && !reset;
    assign mmio_we = memDataBackendIF.we && (region_dec == REGION_MMIO_OUT);

    jzjpcc_inferred_sram #(
        .INITIAL_MEM_CONTENTS (INITIAL_MEM_CONTENTS),
        .A_WIDTH              (RAM_A_WIDTH)
    ) u_sram (
        .clock  (clock),
        .addr_a (fetch_word_addr[RAM_A_WIDTH-1:0]),
        .we_a   (1'b0),
        .mask_a (4'b0000),
        .d_a    (32'h0),
        .q_a    (sram_q_a),
        .addr_b (data_word_addr[RAM_A_WIDTH-1:0]),
        .we_b   (ram_we),
        .mask_b (memDataBackendIF.bytemask),
        .d_b    (memDataBackendIF.wdata),
        .q_b    (sram_q_b)
    );

    jzjpcc_mmio_regfile #(
        .MMIO_COUNT (MMIO_COUNT)
    ) u_mmio (
        .clock     (clock),
        .reset     (reset),
        .write_en  (mmio_we),
        .select_in (region_dec == REGION_MMIO_IN),
        .index     (mmio_index),
        .wdata     (memDataBackendIF.wdata),
        .bytemask  (memDataBackendIF.bytemask),
        .inputs    (mmioInputs),
        .outputs   (mmioOutputs),
        .rdata     (mmio_rdata)
    );

    // A faulting access latches NONE so the memory stage reads back zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            region_q    <= REGION_NONE;
            accessFault <= 1'b0;
        end else begin
            region_q    <= illegal ? REGION_NONE : region_dec;
            accessFault <= illegal;
        end
    end

    always_comb begin
        mem_data_read = '0;
        case (region_q)
            REGION_RAM:                      mem_data_read = sram_q_b;
            REGION_MMIO_OUT, REGION_MMIO_IN: mem_data_read = mmio_rdata;
            default:                         mem_data_read = '0;
        endcase
    end

    assign memDataBackendIF.rdata = mem_data_read;

    assign fetch_be          = toBigEndian32(sram_q_a);
    assign instruction_fetch = fetch_be[31:2];

endmodule
